// File: rtl/intr_sequencer.sv
// Interrupt entry/exit sequencer for the 8-bit pipelined CPU.
// Latches edge-triggered requests and applies the mask and a fixed priority
// (lowest index wins). It waits for a clean pipeline, then pulses the
// acknowledge with a vector address and holds the active-ISR flag until RTI.
module intr_sequencer #(
  parameter int unsigned NUM_SRC      = 4,
  parameter logic [7:0]  VEC_BASE     = 8'h02,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               pipe_stall,
  input  logic               branch_pending,
  input  logic               rti_exec,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               intr_ack,
  output logic               flush_req,
  output logic               intr_active,
  output logic               vec_valid,
  output logic [7:0]         vec_addr,
  output logic [2:0]         src_id
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned SRC_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ACK    = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   src_id_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic               req;
  logic               clean;
  logic [SRC_W-1:0]   winner;
  logic               found;

  // Request path: edge detection, masking and lowest-index priority pick
  always_comb begin
    rise    = irq & ~irq_q;
    req_vec = pending & mask;
    req     = |req_vec;
    clean   = ~pipe_stall & ~branch_pending;
    winner  = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (req_vec[i] && !found) begin
        winner = SRC_W'(i);
        found  = 1'b1;
      end
    end
  end

  // Next-state, drain counter, source latch, pending and mask updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_id_d  = src_id;
    mask_d    = mask_we ? mask_wdata : mask;
    clr_vec   = '0;
    if (state_q == ACK) begin
      clr_vec = NUM_SRC'(1) << src_id;
    end
    // a new edge in the clearing cycle wins over the clear
    pending_d = (pending & ~clr_vec) | rise;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (!req) begin
          state_d = IDLE;
        end else if (clean) begin
          if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            state_d  = ACK;
            src_id_d = winner;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ACK: begin
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (rti_exec) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      irq_q       <= irq;
      pending     <= '0;
      mask        <= '1;
      cnt_q       <= '0;
      src_id      <= '0;
      intr_ack    <= 1'b0;
      flush_req   <= 1'b0;
      vec_valid   <= 1'b0;
      intr_active <= 1'b0;
      vec_addr    <= VEC_BASE;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq;
      pending     <= pending_d;
      mask        <= mask_d;
      cnt_q       <= cnt_d;
      src_id      <= src_id_d;
      intr_ack    <= (state_d == ACK);
      flush_req   <= (state_d == ACK);
      vec_valid   <= (state_d == ACK);
      intr_active <= (state_d == ACK) || (state_d == ACTIVE);
      vec_addr    <= VEC_BASE + 8'(src_id_d);
    end
  end

endmodule
